// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: registered, handshaked MIPS instruction decode stage.
// Decodes the incoming instruction into a control word and holds it in a
// one-entry output register. Detects load-use hazards against the held word
// and inserts a single bubble. Supports flush and downstream backpressure.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-low reset
//   in_valid_i / in_ready_o   upstream handshake (in_ready_o combinational)
//   instr_i                   32-bit instruction
//   flush_i                   kill held word, block input this cycle
//   out_valid_o / out_ready_i downstream handshake
//   RegWrite_o .. Jump_o      1-bit control flags
//   RegDst_o                  00=rt, 01=rd, 10=$31
//   ALU_op_o                  ALU-op class, zero-extended
//   rs_o, rt_o, rd_o          held register fields
//   illegal_o                 held opcode undefined
//   stall_cnt_o               saturating count of inserted bubbles
module ctrl_decode_stage #(
    parameter int unsigned ALUOP_W     = 3,
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [31:0]            instr_i,
    input  logic                   flush_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   RegWrite_o,
    output logic                   ALUSrc_o,
    output logic                   Branch_o,
    output logic                   BranchNe_o,
    output logic                   MemRead_o,
    output logic                   MemWrite_o,
    output logic                   MemtoReg_o,
    output logic                   Jump_o,
    output logic [1:0]             RegDst_o,
    output logic [ALUOP_W-1:0]     ALU_op_o,
    output logic [REG_ADDR_W-1:0]  rs_o,
    output logic [REG_ADDR_W-1:0]  rt_o,
    output logic [REG_ADDR_W-1:0]  rd_o,
    output logic                   illegal_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

    typedef struct packed {
        logic               reg_write;
        logic               alu_src;
        logic               branch;
        logic               branch_ne;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               jump;
        logic [1:0]         reg_dst;
        logic [ALUOP_W-1:0] alu_op;
        logic               illegal;
    } ctrl_t;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    ctrl_t                  ctrl_q, ctrl_d;
    logic [REG_ADDR_W-1:0]  rs_q, rs_d;
    logic [REG_ADDR_W-1:0]  rt_q, rt_d;
    logic [REG_ADDR_W-1:0]  rd_q, rd_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [OP_W-1:0]        op_c;
    logic [REG_ADDR_W-1:0]  rs_in_c;
    logic [REG_ADDR_W-1:0]  rt_in_c;
    logic [REG_ADDR_W-1:0]  rd_in_c;
    ctrl_t                  dec_c;
    logic                   uses_rs_c;
    logic                   uses_rt_c;
    logic                   hazard_c;
    logic                   accept_c;

    // Immediate/shamt/funct bits are not needed by this stage.
    logic                   unused_instr_bits;
    assign unused_instr_bits = ^instr_i[10:0];

    assign op_c    = instr_i[31:26];
    assign rs_in_c = REG_ADDR_W'(instr_i[25:21]);
    assign rt_in_c = REG_ADDR_W'(instr_i[20:16]);
    assign rd_in_c = REG_ADDR_W'(instr_i[15:11]);

    // Opcode decode of the incoming instruction; undefined opcodes only raise illegal.
    always_comb begin
        dec_c     = '0;
        uses_rs_c = 1'b0;
        uses_rt_c = 1'b0;
        case (op_c)
            OP_RTYPE: begin
                dec_c.reg_write = 1'b1;
                dec_c.reg_dst   = 2'b01;
                dec_c.alu_op    = ALUOP_W'(3'b010);
                uses_rs_c       = 1'b1;
                uses_rt_c       = 1'b1;
            end
            OP_ADDI: begin
                dec_c.reg_write = 1'b1;
                dec_c.alu_src   = 1'b1;
                dec_c.alu_op    = ALUOP_W'(3'b000);
                uses_rs_c       = 1'b1;
            end
            OP_BEQ: begin
                dec_c.branch    = 1'b1;
                dec_c.alu_op    = ALUOP_W'(3'b001);
                uses_rs_c       = 1'b1;
                uses_rt_c       = 1'b1;
            end
            OP_BNE: begin
                dec_c.branch    = 1'b1;
                dec_c.branch_ne = 1'b1;
                dec_c.alu_op    = ALUOP_W'(3'b001);
                uses_rs_c       = 1'b1;
                uses_rt_c       = 1'b1;
            end
            OP_SLTI: begin
                dec_c.reg_write = 1'b1;
                dec_c.alu_src   = 1'b1;
                dec_c.alu_op    = ALUOP_W'(3'b011);
                uses_rs_c       = 1'b1;
            end
            OP_ORI: begin
                dec_c.reg_write = 1'b1;
                dec_c.alu_src   = 1'b1;
                dec_c.alu_op    = ALUOP_W'(3'b100);
                uses_rs_c       = 1'b1;
            end
            OP_LUI: begin
                dec_c.reg_write = 1'b1;
                dec_c.alu_src   = 1'b1;
                dec_c.alu_op    = ALUOP_W'(3'b101);
            end
            OP_LW: begin
                dec_c.reg_write  = 1'b1;
                dec_c.alu_src    = 1'b1;
                dec_c.mem_read   = 1'b1;
                dec_c.mem_to_reg = 1'b1;
                uses_rs_c        = 1'b1;
            end
            OP_SW: begin
                dec_c.alu_src   = 1'b1;
                dec_c.mem_write = 1'b1;
                uses_rs_c       = 1'b1;
                uses_rt_c       = 1'b1;
            end
            OP_J: begin
                dec_c.jump = 1'b1;
            end
            OP_JAL: begin
                dec_c.jump      = 1'b1;
                dec_c.reg_write = 1'b1;
                dec_c.reg_dst   = 2'b10;
            end
            default: begin
                dec_c.illegal = 1'b1;
            end
        endcase
    end

    // Load-use: held load writes rt, and the incoming instruction reads that register.
    assign hazard_c = in_valid_i & out_valid_o & ctrl_q.mem_read & (rt_q != '0) &
                      ((uses_rs_c & (rs_in_c == rt_q)) | (uses_rt_c & (rt_in_c == rt_q)));

    assign in_ready_o = rst_i & ~flush_i & ~hazard_c & (~out_valid_o | out_ready_i);
    assign accept_c   = in_valid_i & in_ready_o;

    // Next-state: flush wins; otherwise load on accept, drain on consume, else hold.
    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        stall_cnt_d = stall_cnt_q;

        if (flush_i) begin
            state_d = S_EMPTY;
            ctrl_d  = '0;
            rs_d    = '0;
            rt_d    = '0;
            rd_d    = '0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept_c) begin
                        state_d = S_FULL;
                        ctrl_d  = dec_c;
                        rs_d    = rs_in_c;
                        rt_d    = rt_in_c;
                        rd_d    = rd_in_c;
                    end
                end
                S_FULL: begin
                    if (accept_c) begin
                        ctrl_d = dec_c;
                        rs_d   = rs_in_c;
                        rt_d   = rt_in_c;
                        rd_d   = rd_in_c;
                    end else if (out_ready_i) begin
                        // Drain to EMPTY; under a hazard this empty cycle is the bubble.
                        state_d = S_EMPTY;
                        ctrl_d  = '0;
                        rs_d    = '0;
                        rt_d    = '0;
                        rd_d    = '0;
                        if (hazard_c && (stall_cnt_q != STALL_MAX)) begin
                            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    // State and held-word registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= S_EMPTY;
            ctrl_q      <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid_o = (state_q == S_FULL);
    assign RegWrite_o  = ctrl_q.reg_write;
    assign ALUSrc_o    = ctrl_q.alu_src;
    assign Branch_o    = ctrl_q.branch;
    assign BranchNe_o  = ctrl_q.branch_ne;
    assign MemRead_o   = ctrl_q.mem_read;
    assign MemWrite_o  = ctrl_q.mem_write;
    assign MemtoReg_o  = ctrl_q.mem_to_reg;
    assign Jump_o      = ctrl_q.jump;
    assign RegDst_o    = ctrl_q.reg_dst;
    assign ALU_op_o    = ctrl_q.alu_op;
    assign illegal_o   = ctrl_q.illegal;
    assign rs_o        = rs_q;
    assign rt_o        = rt_q;
    assign rd_o        = rd_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench for ctrl_decode_stage: the driver pushes the expected
// control word on every accepted instruction; a monitor pops and compares
// on each downstream transfer and checks that an empty stage reads all-zero.
module tb_ctrl_decode_stage;

    localparam int unsigned ALUOP_W     = 3;
    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned STALL_CNT_W = 2;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [31:0]            instr_i;
    logic                   flush_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic                   RegWrite_o, ALUSrc_o, Branch_o, BranchNe_o;
    logic                   MemRead_o, MemWrite_o, MemtoReg_o, Jump_o;
    logic [1:0]             RegDst_o;
    logic [ALUOP_W-1:0]     ALU_op_o;
    logic [REG_ADDR_W-1:0]  rs_o, rt_o, rd_o;
    logic                   illegal_o;
    logic [STALL_CNT_W-1:0] stall_cnt_o;

    ctrl_decode_stage #(
        .ALUOP_W    (ALUOP_W),
        .REG_ADDR_W (REG_ADDR_W),
        .STALL_CNT_W(STALL_CNT_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .instr_i    (instr_i),
        .flush_i    (flush_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .RegWrite_o (RegWrite_o),
        .ALUSrc_o   (ALUSrc_o),
        .Branch_o   (Branch_o),
        .BranchNe_o (BranchNe_o),
        .MemRead_o  (MemRead_o),
        .MemWrite_o (MemWrite_o),
        .MemtoReg_o (MemtoReg_o),
        .Jump_o     (Jump_o),
        .RegDst_o   (RegDst_o),
        .ALU_op_o   (ALU_op_o),
        .rs_o       (rs_o),
        .rt_o       (rt_o),
        .rd_o       (rd_o),
        .illegal_o  (illegal_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int          vectors    = 0;
    int          miscompares = 0;
    int          cyc        = 0;
    logic [28:0] sb[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    // Word layout: {RegWrite,ALUSrc,Branch,BranchNe,MemRead,MemWrite,MemtoReg,Jump,RegDst,ALU_op,illegal,rs,rt,rd}
    function automatic logic [28:0] model(input logic [31:0] ins);
        logic [7:0] f;
        logic [1:0] rdst;
        logic [2:0] al;
        logic       ill;
        f = 8'h00; rdst = 2'b00; al = 3'b000; ill = 1'b0;
        case (ins[31:26])
            6'h00: begin f = 8'b1000_0000; rdst = 2'b01; al = 3'b010; end
            6'h08: begin f = 8'b1100_0000; al = 3'b000; end
            6'h04: begin f = 8'b0010_0000; al = 3'b001; end
            6'h05: begin f = 8'b0011_0000; al = 3'b001; end
            6'h0A: begin f = 8'b1100_0000; al = 3'b011; end
            6'h0D: begin f = 8'b1100_0000; al = 3'b100; end
            6'h0F: begin f = 8'b1100_0000; al = 3'b101; end
            6'h23: begin f = 8'b1100_1010; end
            6'h2B: begin f = 8'b0100_0100; end
            6'h02: begin f = 8'b0000_0001; end
            6'h03: begin f = 8'b1000_0001; rdst = 2'b10; end
            default: ill = 1'b1;
        endcase
        return {f, rdst, al, ill, ins[25:21], ins[20:16], ins[15:11]};
    endfunction

    function automatic logic [28:0] dut_word();
        return {RegWrite_o, ALUSrc_o, Branch_o, BranchNe_o, MemRead_o, MemWrite_o,
                MemtoReg_o, Jump_o, RegDst_o, ALU_op_o, illegal_o, rs_o, rt_o, rd_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare on each transfer, require zeros while empty.
    always @(negedge clk_i) begin
        if (rst_i) begin
            if (out_valid_o && out_ready_i) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(dut_word()), 32'hFFFF_FFFF);
                end else begin
                    check("scoreboard", 32'(dut_word()), 32'(sb.pop_front()));
                end
            end else if (!out_valid_o) begin
                check("empty_reads_zero", 32'(dut_word()), 32'h0);
            end
        end
    end

    // Present one instruction until accepted; returns the accept cycle.
    task automatic send(input logic [31:0] ins, output int acc);
        logic rdy;
        bit   done;
        done       = 1'b0;
        acc        = -1;
        in_valid_i = 1'b1;
        instr_i    = ins;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk_i);
            rdy = in_ready_o;
            @(posedge clk_i);
            if (rdy) begin
                sb.push_back(model(ins));
                done = 1'b1;
            end
            #1;
            if (rdy) acc = cyc;
        end
        in_valid_i = 1'b0;
        if (!done) check("accept_timeout", 32'(ins), 32'h0);
    endtask

    int c1, c2;
    int exp_stall;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i       = 1'b0;
        in_valid_i  = 1'b1;
        instr_i     = 32'h2008_0005;
        flush_i     = 1'b0;
        out_ready_i = 1'b1;
        exp_stall   = 0;

        // Reset held with input valid
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_out_valid", 32'(out_valid_o), 32'h0);
        check("rst_in_ready",  32'(in_ready_o),  32'h0);
        check("rst_stall_cnt", 32'(stall_cnt_o), 32'h0);
        check("rst_word",      32'(dut_word()),  32'h0);
        in_valid_i = 1'b0;
        rst_i      = 1'b1;
        @(posedge clk_i); #1;

        send(32'h2008_0005, c1);
        @(negedge clk_i);
        check("addi_latency", 32'(out_valid_o), 32'h1);
        @(posedge clk_i); #1;

        // Load-use on rs/rt: one bubble each
        send(32'h8C08_0000, c1);
        send(32'h0108_4820, c2);
        check("lu_add_distance", 32'(c2 - c1), 32'd2);
        exp_stall = 1;
        check("lu_add_stall", 32'(stall_cnt_o), 32'(exp_stall));

        send(32'h8C00_0000, c1);
        send(32'h0000_4820, c2);
        check("lw_r0_distance", 32'(c2 - c1), 32'd1);
        check("lw_r0_stall", 32'(stall_cnt_o), 32'(exp_stall));

        send(32'h8C08_0000, c1);
        send(32'hAD28_0000, c2);
        check("lu_sw_rt_distance", 32'(c2 - c1), 32'd2);
        exp_stall = 2;
        check("lu_sw_rt_stall", 32'(stall_cnt_o), 32'(exp_stall));

        send(32'h8C08_0000, c1);
        send(32'h2008_0001, c2);
        check("lw_addi_rt_unused_distance", 32'(c2 - c1), 32'd1);
        check("lw_addi_rt_unused_stall", 32'(stall_cnt_o), 32'(exp_stall));

        // Backpressure: sw held for 3 cycles, ori waits
        repeat (2) @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        send(32'hAD28_0000, c1);
        in_valid_i = 1'b1;
        instr_i    = 32'h3529_00FF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("bp_in_ready", 32'(in_ready_o), 32'h0);
            check("bp_hold_word", 32'(dut_word()), 32'(model(32'hAD28_0000)));
            check("bp_hold_valid", 32'(out_valid_o), 32'h1);
            @(posedge clk_i); #1;
        end
        out_ready_i = 1'b1;
        send(32'h3529_00FF, c2);
        check("bp_release_distance", 32'(c2 - c1), 32'd4);
        @(negedge clk_i);
        check("bp_next_valid", 32'(out_valid_o), 32'h1);

        // Flush while beq held and input valid
        repeat (2) @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        send(32'h1109_0003, c1);
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        instr_i    = 32'h2008_0005;
        @(negedge clk_i);
        check("flush_in_ready", 32'(in_ready_o), 32'h0);
        @(posedge clk_i); #1;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        void'(sb.pop_back());
        @(negedge clk_i);
        check("flush_out_valid", 32'(out_valid_o), 32'h0);
        check("flush_stall", 32'(stall_cnt_o), 32'(exp_stall));
        out_ready_i = 1'b1;
        repeat (3) @(posedge clk_i); #1;

        // Opcode sweep
        for (int op = 0; op < 64; op++) begin
            send({6'(op), 5'd1, 5'd2, 5'd3, 11'd0}, c1);
        end
        repeat (2) @(posedge clk_i); #1;

        // Saturation of the 2-bit bubble counter
        for (int i = 0; i < 5; i++) begin
            send(32'h8C08_0000, c1);
            send(32'h0108_4820, c2);
            exp_stall = (exp_stall < 3) ? exp_stall + 1 : 3;
            check("sat_distance", 32'(c2 - c1), 32'd2);
            check("sat_stall", 32'(stall_cnt_o), 32'(exp_stall));
        end
        check("sat_final", 32'(stall_cnt_o), 32'd3);

        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
